e203_btn_debounce: RTL
======================

E203_BTN_DEBOUNCE -- requirements
Module: e203_btn_debounce

Interface
REQ-001 Parameter NUM_BTN, default 5: number of button channels; legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYC, default 1000: number of stable clk cycles required to accept a new level; legal range 1..65535.
REQ-003 Parameter BTN_POL, default 0: 0 means a pad is pressed when high; 1 means a pad is pressed when low (the pad is inverted after synchronization).
REQ-004 clk  input  1  single system clock; all flops are on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn_i  input  NUM_BTN  raw, asynchronous button pads.
REQ-007 btn_o  output  NUM_BTN  debounced level; drives io_pads_gpioA_i_ival bits 3..7.
REQ-008 rise_o  output  NUM_BTN  one-cycle pulse on each accepted press.
REQ-009 fall_o  output  NUM_BTN  one-cycle pulse on each accepted release.
REQ-010 ie_i  input  NUM_BTN  per-channel interrupt enable.
REQ-011 clr_i  input  NUM_BTN  per-channel pending-clear pulse.
REQ-012 pend_o  output  NUM_BTN  latched press-pending flags.
REQ-013 irq_o  output  1  aggregate press interrupt.

Function
REQ-014 Each channel SHALL pass btn_i through a 2-flop synchronizer, then apply the BTN_POL inversion, to produce sync.
REQ-015 Each channel SHALL run a 4-state FSM: LO, CHK_HI, HI, CHK_LO.
- LO: sync=1 -> CHK_HI with cnt=0.
- CHK_HI: sync=0 -> LO (glitch rejected, no pulse); sync=1 with cnt==DEBOUNCE_CYC-1 -> HI; otherwise cnt+1.
- HI and CHK_LO: symmetric to LO and CHK_HI.
REQ-016 The counter SHALL be 16 bits wide; it SHALL never wrap and SHALL never exceed DEBOUNCE_CYC-1.
REQ-017 btn_o SHALL be 1 exactly in state HI or CHK_LO, and SHALL be registered.
REQ-018 Latency from first clk edge sampling a steady pressed pad to btn_o=1 SHALL be DEBOUNCE_CYC+3 edges; release latency SHALL be identical.
REQ-019 rise_o SHALL pulse for one cycle, on the same edge that btn_o goes 1; fall_o SHALL pulse for one cycle, on the same edge that btn_o goes 0; the two SHALL never be high together on one channel.
REQ-020 The CHK_HI->HI transition SHALL set pend_o[i] on the same edge as rise_o[i].
REQ-021 clr_i[i]=1 SHALL clear pend_o[i] on the next edge; simultaneous set and clear SHALL leave pend_o[i]=1 (set wins).
REQ-022 irq_o SHALL be registered, equal to OR-reduce(pend_o & ie_i) delayed one cycle; changing ie_i SHALL affect irq_o one cycle later without altering pend_o.
REQ-023 Channels SHALL be fully independent; simultaneous events on any channels SHALL all be captured.

Reset
REQ-024 rst_n=0 SHALL asynchronously force:
- synchronizer flops to BTN_POL (unpressed);
- FSM to LO, cnt=0;
- btn_o, rise_o, fall_o, pend_o, irq_o to 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; reset deassertion with a pad held pressed SHALL produce a full DEBOUNCE_CYC+3 latency and one rise_o pulse.

Configuration
REQ-026 Macro E203_BTN_DEBOUNCE_IRQ_EN:
- When defined, the pend_o/irq_o logic of REQ-020..022 SHALL be compiled in.
- When undefined, pend_o and irq_o SHALL be tied to 0, ie_i and clr_i SHALL be ignored, and no pending flops SHALL exist.
- btn_o, rise_o and fall_o SHALL behave identically in both cases.

Structure
REQ-027 FSM state encodings (2-bit) and the counter width constant SHALL live in the shared e203 defines include.
REQ-028 Per-channel synchronizer, FSM and counter SHALL be one sub-module, e203_btn_debounce_ch, instantiated NUM_BTN times by generate.
- The pending and irq logic SHALL stay in the top module.

Verification (bench: DEBOUNCE_CYC=8, BTN_POL=0, NUM_BTN=5, E203_BTN_DEBOUNCE_IRQ_EN defined)
REQ-029 Hold btn_i[0]=1 steady from edge 1 -> btn_o[0]=1 and rise_o[0]=1 at edge 11, pend_o[0]=1 at edge 11, irq_o=1 at edge 12 with ie_i[0]=1.
REQ-030 Pulse btn_i[2]=1 for 6 cycles then 0 -> btn_o[2] stays 0, and there are no rise_o or pend_o events.
REQ-031 Press btn_i[1] and btn_i[4] on the same edge -> rise_o=5'b10010 on a single edge, pend_o=5'b10010.
REQ-032 pend_o[3]=1, then assert clr_i[3] on the same edge as a new rise_o[3] -> pend_o[3] remains 1; clr_i[3] alone one cycle later -> pend_o[3]=0 and irq_o=0 on the following edge.
REQ-033 Assert rst_n=0 for 2 cycles at cnt=5 on a pressed channel -> all outputs 0 immediately; after release with the pad held -> rise_o pulses at DEBOUNCE_CYC+3=11 edges after deassertion.
REQ-034 Rebuild with E203_BTN_DEBOUNCE_IRQ_EN undefined and run REQ-029 -> btn_o timing unchanged, pend_o=0, irq_o=0.

Source files
------------

// File: rtl/e203_btn_debounce_pkg.sv
// Shared constants for the e203 button debouncer: FSM state encodings and counter width.
package e203_btn_debounce_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_LO     = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HI     = 2'd2,
    ST_CHK_LO = 2'd3
  } btn_st_e;

endpackage

// File: rtl/e203_btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, polarity fix, 4-state debounce FSM with
// saturating counter, registered level and edge pulses.
module e203_btn_debounce_ch
  import e203_btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000,
  parameter int unsigned BTN_POL      = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_c
);

  localparam logic             POL     = 1'(BTN_POL);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             sync;
  btn_st_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_d;
  logic             fall_c;

  // Synchronizer resets to the unpressed pad level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{POL}};
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign sync = sync_q[1] ^ POL;

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      btn_o   <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_o   <= btn_d;
      rise_o  <= rise_c;
      fall_o  <= fall_c;
    end
  end

  // Next-state: counter only advances while below CNT_MAX, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LO: begin
        if (sync) begin
          state_d = ST_CHK_HI;
          cnt_d   = '0;
        end
      end
      ST_CHK_HI: begin
        if (!sync) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!sync) begin
          state_d = ST_CHK_LO;
          cnt_d   = '0;
        end
      end
      ST_CHK_LO: begin
        if (sync) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so the registered level lands on the accepting edge.
  always_comb begin
    btn_d  = 1'b0;
    rise_c = 1'b0;
    fall_c = 1'b0;
    btn_d  = (state_d == ST_HI) || (state_d == ST_CHK_LO);
    rise_c = (state_q == ST_CHK_HI) && (state_d == ST_HI);
    fall_c = (state_q == ST_CHK_LO) && (state_d == ST_LO);
  end

endmodule

// File: rtl/e203_btn_debounce.sv
// Multi-channel button debouncer with press-pending flags and aggregate interrupt.
// Pending/irq logic is built only when E203_BTN_DEBOUNCE_IRQ_EN is defined.
module e203_btn_debounce
  import e203_btn_debounce_pkg::*;
#(
  parameter int unsigned NUM_BTN      = 5,
  parameter int unsigned DEBOUNCE_CYC = 1000,
  parameter int unsigned BTN_POL      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_BTN-1:0] rise_o,
  output logic [NUM_BTN-1:0] fall_o,
  input  logic [NUM_BTN-1:0] ie_i,
  input  logic [NUM_BTN-1:0] clr_i,
  output logic [NUM_BTN-1:0] pend_o,
  output logic               irq_o
);

  logic [NUM_BTN-1:0] rise_c;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    e203_btn_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .BTN_POL     (BTN_POL)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (btn_i[g]),
      .btn_o (btn_o[g]),
      .rise_o(rise_o[g]),
      .fall_o(fall_o[g]),
      .rise_c(rise_c[g])
    );
  end

`ifdef E203_BTN_DEBOUNCE_IRQ_EN
  // Set on the accepting edge; set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_o <= '0;
      irq_o  <= 1'b0;
    end else begin
      pend_o <= (pend_o & ~clr_i) | rise_c;
      irq_o  <= |(pend_o & ie_i);
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{ie_i, clr_i, rise_c};
  assign pend_o = '0;
  assign irq_o  = 1'b0;
`endif

endmodule
